// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and constants for the transmit and receive paths
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;
    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: valid/ready byte handshake into the UART transmitter
interface uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    modport master (output tx_data, tx_valid, input tx_ready);
    modport slave  (input tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: oversampling tick every max(dvsr,1) clocks, synchronous clear
module uart_baud_gen #(
    parameter int DVSR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [DVSR_W-1:0] dvsr,
    output logic              tick,
    output logic              tick_nxt
);
    logic [DVSR_W-1:0] cnt_q, cnt_d, lim;
    always_comb begin
        lim      = (dvsr == '0) ? '0 : dvsr - 1'b1;
        tick     = cnt_q >= lim;
        cnt_d    = (clear || tick) ? '0 : cnt_q + 1'b1;
        // lets the owner register outputs that must line up with the next tick
        tick_nxt = cnt_d >= lim;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1/8N2 serialiser with valid/ready input and one-cycle tx_done pulse
// UART_TX_PARITY_EN adds an even-parity bit between the data and stop bits
module uart_tx
    import uart_pkg::*;
#(
    parameter int DVSR_W    = 11,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DVSR_W-1:0] dvsr,
    uart_tx_if.slave          tx,
    output logic              serial_out,
    output logic              tx_busy,
    output logic              tx_done
);
    uart_tx_state_t    state_q, state_d;
    logic [7:0]        shreg_q, shreg_d;
    logic [3:0]        s_q, s_d;
    logic [2:0]        n_q, n_d;
    logic [DVSR_W-1:0] dvsr_q, dvsr_d;
    logic              out_q, out_d, busy_q, busy_d, done_q, done_d;
    logic              tick, tick_nxt, accept, bnd;
`ifdef UART_TX_PARITY_EN
    logic              par_q, par_d;
`endif
    assign accept      = tx.tx_valid && (state_q == IDLE);
    assign bnd         = tick && (s_q == 4'(OVERSAMPLE - 1));
    assign tx.tx_ready = ~busy_q;
    assign serial_out  = out_q;
    assign tx_busy     = busy_q;
    assign tx_done     = done_q;
    uart_baud_gen #(.DVSR_W(DVSR_W)) u_baud (
        .clk(clk), .rst(rst), .clear(accept), .dvsr(dvsr_q), .tick(tick), .tick_nxt(tick_nxt)
    );
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        n_d     = n_q;
        dvsr_d  = dvsr_q;
        s_d     = (state_q != IDLE && tick) ? s_q + 4'd1 : s_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: if (accept) begin
                state_d = START;
                shreg_d = tx.tx_data;
                dvsr_d  = dvsr;
                s_d     = '0;
                n_d     = '0;
`ifdef UART_TX_PARITY_EN
                par_d   = ^tx.tx_data;
`endif
            end
            START: if (bnd) state_d = DATA;
            DATA: if (bnd) begin
                shreg_d = shreg_q >> 1;
                n_d     = n_q + 3'd1;
`ifdef UART_TX_PARITY_EN
                if (n_q == 3'(DATA_BITS - 1)) state_d = PARITY;
`else
                if (n_q == 3'(DATA_BITS - 1)) state_d = STOP;
`endif
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bnd) state_d = STOP;
`endif
            STOP: if (bnd) begin
                n_d = n_q + 3'd1;
                if (n_q == 3'(STOP_BITS - 1)) begin
                    state_d = IDLE;
                    n_d     = '0;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef UART_TX_PARITY_EN
        out_d  = (state_d == START) ? 1'b0 : (state_d == DATA) ? shreg_d[0] : (state_d == PARITY) ? par_q : 1'b1;
`else
        out_d  = (state_d == START) ? 1'b0 : (state_d == DATA) ? shreg_d[0] : 1'b1;
`endif
        busy_d = state_d != IDLE;
        // registered pulse: raised one edge early so it covers the final tick of the last stop bit
        done_d = (state_d == STOP) && (s_d == 4'(OVERSAMPLE - 1)) && (n_d == 3'(STOP_BITS - 1)) && tick_nxt;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            s_q     <= '0;
            n_q     <= '0;
            dvsr_q  <= '0;
            out_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            s_q     <= s_d;
            n_q     <= n_d;
            dvsr_q  <= dvsr_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end
endmodule

// File: doc/uart_tx.md
# uart_tx

Transmit half of the UART system: serialises bytes onto `serial_out` as 8N1 frames (start, 8 data bits LSB-first, stop), using the same 16× oversampled baud tick and the same runtime `dvsr` divisor scheme as the receive path. It sits beside the receiver under `uart_system_top` and shares its clock, reset and divisor. Bytes enter through a valid/ready handshake; the block reports completion with a one-cycle `tx_done` pulse.

## Interface
- `DVSR_W`, default 11: width of the `dvsr` input.
- `STOP_BITS`, default 1: number of stop bits. Legal values are 1 or 2.
- `clk` input 1: system clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `dvsr` input DVSR_W: baud-tick divisor. One tick occurs every max(dvsr,1) clocks. One bit lasts 16 ticks.
- `tx_data` input 8: byte to send.
- `tx_valid` input 1: `tx_data` is valid.
- `tx_ready` output 1: the block can accept a byte. High only in IDLE.
- `serial_out` output 1: serial line, registered, idles high.
- `tx_busy` output 1: high from acceptance until the end of the last stop bit.
- `tx_done` output 1: one-cycle pulse on the clock where the last stop bit ends.

## Operation
- Reset values:
  - state = IDLE
  - `serial_out` = 1
  - `tx_ready` = 1
  - `tx_busy` = 0
  - `tx_done` = 0
  - tick and bit counters = 0
- Reset is asynchronous. When asserted mid-frame, `serial_out` goes high immediately and the frame is abandoned. No `tx_done` is issued.
- Handshake: a transfer occurs on a clock edge where `tx_valid && tx_ready`. At that edge `tx_data` and `dvsr` are latched. Later changes to either input have no effect on the frame in progress.
- States:
  - IDLE: leaves on a transfer to START.
  - START: drives 0 for 16 ticks, then goes to DATA.
  - DATA: drives shift-register bit 0 and shifts right after every 16 ticks. After 8 bits it goes to PARITY (parity enabled) or STOP.
  - PARITY: drives 1 bit for 16 ticks, then goes to STOP.
  - STOP: drives 1 for 16×STOP_BITS ticks, then returns to IDLE.
- Tick generator:
  - The counter runs 0..max(dvsr,1)−1 and ticks on the terminal count.
  - It is cleared on acceptance, so the start bit lasts exactly 16·max(dvsr,1) clocks.
  - `dvsr=0` behaves exactly like `dvsr=1`.
- Counter widths: tick counter is DVSR_W bits, sub-bit counter is 4 bits (wraps 15→0 and marks a bit boundary), bit counter is 3 bits.

## Timing
- Latency: on the edge after acceptance, `serial_out` = 0 and `tx_busy` = 1.
- Bit period: T = 16·max(dvsr,1) clocks.
- Frame length: (10 + STOP_BITS − 1 + parity) · T clocks.
- End of frame: `tx_done` pulses on the final clock of the stop period. State is IDLE and `tx_ready` = 1 on the following edge.
- Back-to-back: with `tx_valid` held high, there is exactly one idle clock (`serial_out` high) between frames.
- `tx_ready` and `tx_busy` are always complementary.

## Configuration
- `UART_TX_PARITY_EN` defined: a PARITY state is inserted between DATA and STOP. The parity bit is the even-parity bit, ^tx_data, and the frame grows by T.
- `UART_TX_PARITY_EN` undefined: the PARITY state, its logic and the parity register are absent, and frames are pure 8N1/8N2.

## Structure
- `uart_pkg` holds:
  - the `uart_tx_state_t` enum (IDLE, START, DATA, PARITY, STOP)
  - `OVERSAMPLE = 16`
  - `DATA_BITS = 8`
- The receiver uses the same package.
- Sub-module `uart_baud_gen`: the divisor counter producing `tick`, with a synchronous `clear` input. It is reusable by the receiver.
- `uart_tx` instantiates one `uart_baud_gen` and contains the FSM and the shift register.

## Test plan
- Single byte: `dvsr=2`, send 0xA5. `serial_out` must be 0,1,0,1,0,0,1,0,1,1, each level held 32 clocks. `tx_done` pulses exactly 320 clocks after acceptance.
- Back-to-back: `dvsr=1`, `tx_valid` held high, send 0x00 then 0xFF. Expect two frames of 160 clocks each, separated by exactly one high idle clock. `tx_ready` is low throughout each frame.
- Divisor latching: `dvsr=0` gives 16-clock bits. Change `dvsr` to 4 mid-frame; the current frame must still use 16-clock bits, and the next frame uses 64-clock bits.
- Reset mid-frame: assert `rst` during data bit 3. `serial_out` = 1 and `tx_ready` = 1 with no clock edge, and no `tx_done` is seen. After release, 0x3C transmits correctly.
- Parity (`UART_TX_PARITY_EN`): 0xA5 gives parity bit 0 and 0x07 gives parity bit 1. With `dvsr=1`, the frame is 176 clocks.
- `STOP_BITS=2`: 0x55 at `dvsr=1` gives a stop high level of 32 clocks, and `tx_done` fires at clock 176.
